// File: rtl/cp_removal_ctrl.sv
// ---------------------------------------------------------------------------
// cp_removal_ctrl
//
// Cyclic-prefix removal sequencer for OFDM symbols on an AXI-Stream path.
// For every symbol the first cfg_cp_len input samples are accepted and
// discarded. The following cfg_nfft samples are forwarded through a single
// output register, and m_axis_tlast marks the last forwarded sample.
// Configuration is latched only at symbol boundaries.
//
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   enable            - start / continue processing symbols
//   cfg_nfft          - useful samples per symbol (0 is a config error)
//   cfg_cp_len        - prefix samples per symbol (0 skips the drop phase)
//   s_axis_*          - input sample stream (tdata/tvalid/tready)
//   m_axis_*          - output sample stream (tdata/tvalid/tready/tlast)
//   sym_count         - completed symbols, wraps at 16 bits
//   cfg_err           - sticky flag: enable seen with cfg_nfft == 0
//   stall             - output stall flag (watchdog build only, else 0)
//
// Optional feature macro: CPR_WATCHDOG_EN
//   When defined, a saturating 16-bit counter measures consecutive
//   backpressured output cycles and raises stall at STALL_LIMIT.
// ---------------------------------------------------------------------------
module cp_removal_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cfg_nfft,
    input  logic [CNT_W-1:0]  cfg_cp_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       sym_count,
    output logic              cfg_err,
    output logic              stall
);

    // The stall counter is 16 bits wide, so the threshold must fit in it.
    if (STALL_LIMIT == 0 || STALL_LIMIT > 65535) begin : g_bad_stall_limit
        $error("cp_removal_ctrl: STALL_LIMIT must be in 1..65535");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DROP,
        ST_PASS
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [CNT_W-1:0]    nfft_q,   nfft_d;
    logic [CNT_W-1:0]    cp_q,     cp_d;
    logic [DATA_W-1:0]   tdata_q,  tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q,  tlast_d;
    logic [15:0]         sym_q,    sym_d;
    logic                err_q,    err_d;

    logic                s_ready;
    logic                s_accept;
    logic                m_pop;
    logic                pass_load;
    logic                cfg_ok;
    state_t              start_state;

    // Input ready: in PASS the output register can take a new sample when
    // it is empty or being emptied in the same cycle.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_DROP: s_ready = 1'b1;
            ST_PASS: s_ready = !tvalid_q || m_axis_tready;
            default: s_ready = 1'b0;
        endcase
    end

    assign s_accept    = s_axis_tvalid && s_ready;
    assign m_pop       = tvalid_q && m_axis_tready;
    assign pass_load   = (state_q == ST_PASS) && s_accept;
    assign cfg_ok      = (cfg_nfft != '0);
    assign start_state = (cfg_cp_len != '0) ? ST_DROP : ST_PASS;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nfft_d   = nfft_q;
        cp_d     = cp_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        sym_d    = sym_q;
        err_d    = err_q;

        // Output register: a PASS accept loads it (covering a simultaneous
        // pop), otherwise a pop empties it. DROP accepts never touch it.
        if (pass_load) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = (cnt_q == nfft_q - CNT_ONE);
        end else if (m_pop) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (cfg_ok) begin
                        nfft_d  = cfg_nfft;
                        cp_d    = cfg_cp_len;
                        cnt_d   = '0;
                        state_d = start_state;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (s_accept) begin
                    if (cnt_q == cp_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_PASS;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_PASS: begin
                if (s_accept) begin
                    if (cnt_q == nfft_q - CNT_ONE) begin
                        cnt_d = '0;
                        sym_d = sym_q + 16'd1;
                        // Symbol boundary: relatch directly so back-to-back
                        // symbols run without an idle cycle.
                        if (enable && cfg_ok) begin
                            nfft_d  = cfg_nfft;
                            cp_d    = cfg_cp_len;
                            state_d = start_state;
                        end else begin
                            if (enable) begin
                                err_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            nfft_q   <= '0;
            cp_q     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sym_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nfft_q   <= nfft_d;
            cp_q     <= cp_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            sym_q    <= sym_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sym_count     = sym_q;
    assign cfg_err       = err_q;

`ifdef CPR_WATCHDOG_EN
    localparam logic [15:0] STALL_LIM = 16'(STALL_LIMIT);

    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Any handshake clears the count, so stall drops the cycle after it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_pop) begin
            stall_cnt_d = '0;
        end else if (tvalid_q && !m_axis_tready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall = (stall_cnt_q >= STALL_LIM);
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_cp_removal_ctrl.sv
module tb_cp_removal_ctrl;

    localparam int DW = 32;
    localparam int CW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] cfg_nfft = '0;
    logic [CW-1:0] cfg_cp_len = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [15:0]   sym_count;
    logic          cfg_err;
    logic          stall;

    cp_removal_ctrl #(
        .DATA_W      (DW),
        .CNT_W       (CW),
        .STALL_LIMIT (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .cfg_nfft      (cfg_nfft),
        .cfg_cp_len    (cfg_cp_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .sym_count     (sym_count),
        .cfg_err       (cfg_err),
        .stall         (stall)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q[$];      // {tlast, tdata} expected at the output
    int          exp_sym = 0;
    int          in_waits = 0;
    int          stall_seen = 0;
    bit          rnd_ready = 1'b0;
    logic        hold_pending = 1'b0;
    logic [DW:0] hold_val;
    logic [DW:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change 1 time unit after posedge, so values seen at
    // negedge are what the next posedge samples.
    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (stall) stall_seen++;
            if (hold_pending) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
                chk("hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(hold_val));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none",
                             {m_axis_tlast, m_axis_tdata});
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("out_sample", 64'({m_axis_tlast, m_axis_tdata}), 64'(mon_exp));
                end
            end
            hold_pending = m_axis_tvalid && !m_axis_tready;
            hold_val     = {m_axis_tlast, m_axis_tdata};
        end
    end

    always @(posedge clock) begin
        #1;
        if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Issue one symbol: cp prefix samples then nfft payload samples. The
    // model expects payload samples in order, tlast on the final one.
    task automatic send_symbol(input int nfft, input int cp, input int base,
                               input bit rand_valid, input bit rand_data,
                               input int drop_en_after, input bit chk_lat,
                               input int max_n);
        int total;
        int waits;
        logic [DW-1:0] d;
        total = nfft + cp;
        for (int i = 0; i < total; i++) begin
            if (max_n >= 0 && i >= max_n) break;
            if (rand_valid) begin
                while ($urandom_range(0, 1) == 1) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clock); #1;
                end
            end
            d = rand_data ? DW'($urandom) : DW'(base + i);
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            if (i >= cp) exp_q.push_back({(i == total - 1), d});
            waits = 0;
            @(negedge clock);
            while (!s_axis_tready && waits < 300) begin
                waits++;
                @(negedge clock);
            end
            if (waits >= 300) begin
                checks++;
                errors++;
                $display("FAIL input_accept_timeout actual=%0d required=<300", waits);
            end
            in_waits += waits;
            @(posedge clock); #1;
            if (i == drop_en_after) enable = 1'b0;
            if (chk_lat && i == cp) begin
                chk("lat_valid", 64'(m_axis_tvalid), 64'(1));
                chk("lat_data", 64'(m_axis_tdata), 64'(d));
            end
        end
        s_axis_tvalid = 1'b0;
        if (max_n < 0) exp_sym++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd_ready = 1'b0;
        m_axis_tready = 1'b1;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        end
    endtask

    task automatic wd_check();
        int n;
        bit wd;
`ifdef CPR_WATCHDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!m_axis_tvalid && n < 100);
        chk("wd_valid_seen", 64'(m_axis_tvalid), 64'(1));
        repeat (9) begin @(posedge clock); #1; end
        chk("wd_stall_9", 64'(stall), 64'(0));
        @(posedge clock); #1;
        chk("wd_stall_10", 64'(stall), 64'(wd));
        m_axis_tready = 1'b1;
        @(posedge clock); #1;
        chk("wd_stall_clear", 64'(stall), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_m_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_sym_count", 64'(sym_count), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Single long symbol with latency check.
        cfg_nfft = 12'd64; cfg_cp_len = 12'd16; enable = 1'b1;
        send_symbol(64, 16, 0, 0, 0, 0, 1, -1);
        drain();
        chk("t1_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));

        // Three back-to-back symbols, no idle between them.
        cfg_nfft = 12'd8; cfg_cp_len = 12'd2; enable = 1'b1;
        in_waits = 0;
        send_symbol(8, 2, 0, 0, 0, -1, 0, -1);
        send_symbol(8, 2, 10, 0, 0, -1, 0, -1);
        send_symbol(8, 2, 20, 0, 0, 0, 0, -1);
        chk("t2_input_waits", 64'(in_waits), 64'(1));
        drain();
        chk("t2_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));

        // Zero prefix, then a zero-length config error.
        cfg_nfft = 12'd8; cfg_cp_len = 12'd0; enable = 1'b1;
        send_symbol(8, 0, 100, 0, 0, 0, 0, -1);
        drain();
        chk("t3_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));
        cfg_nfft = 12'd0; enable = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("t3_err_s_tready", 64'(s_axis_tready), 64'(0));
        end
        chk("t3_cfg_err", 64'(cfg_err), 64'(1));
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("t3_cfg_err_sticky", 64'(cfg_err), 64'(1));

        // Asynchronous reset after 5 of 16 payload samples.
        cfg_nfft = 12'd16; cfg_cp_len = 12'd4; enable = 1'b1;
        send_symbol(16, 4, 200, 0, 0, -1, 0, 9);
        #1;
        reset = 1'b1;
        #1;
        chk("t4_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t4_m_tdata", 64'(m_axis_tdata), 64'(0));
        chk("t4_m_tlast", 64'(m_axis_tlast), 64'(0));
        chk("t4_sym_count", 64'(sym_count), 64'(0));
        chk("t4_cfg_err", 64'(cfg_err), 64'(0));
        exp_q.delete();
        exp_sym = 0;
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        enable = 1'b1;
        send_symbol(16, 4, 300, 0, 0, 0, 0, -1);
        drain();
        chk("t4_fresh_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));

        // enable dropped mid-symbol: symbol completes, then idle.
        cfg_nfft = 12'd8; cfg_cp_len = 12'd2; enable = 1'b1;
        send_symbol(8, 2, 400, 0, 0, 3, 0, -1);
        repeat (3) begin
            @(negedge clock);
            chk("t5_idle_s_tready", 64'(s_axis_tready), 64'(0));
        end
        drain();
        chk("t5_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));

        // Random valid/ready over 100 symbols.
        cfg_nfft = 12'd16; cfg_cp_len = 12'd4; enable = 1'b1;
        rnd_ready = 1'b1;
        for (int s = 0; s < 100; s++) begin
            send_symbol(16, 4, 0, 1, 1, (s == 99) ? 0 : -1, 0, -1);
        end
        drain();
        chk("t6_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));

        // Held backpressure: stall watchdog behaviour.
        cfg_nfft = 12'd4; cfg_cp_len = 12'd0;
        rnd_ready = 1'b0;
        m_axis_tready = 1'b0;
        enable = 1'b1;
        fork
            send_symbol(4, 0, 500, 0, 0, 0, 0, -1);
            wd_check();
        join
        drain();
        chk("t7_sym_count", 64'(sym_count), 64'(exp_sym[15:0]));
        chk("t7_queue_empty", 64'(exp_q.size()), 64'(0));
`ifndef CPR_WATCHDOG_EN
        chk("stall_never_set", 64'(stall_seen), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
